// File: rtl/frame_column_loader_if.sv
// Configuration word stream between the bitstream word assembler and the frame loader.
interface frame_column_loader_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/frame_column_loader.sv
// Turns header+data word packets into per-row FrameData and a single pulsed FrameStrobe bit.
// Optional: define FRAME_CRC_EN to require an XOR check word after the data words.
module frame_column_loader #(
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned NumRows         = 4,
  parameter int unsigned NumCols         = 4,
  parameter int unsigned StrobeCycles    = 2
) (
  input  logic                                 UserCLK,
  input  logic                                 reset,
  frame_column_loader_if.slave                 cfg,
  output logic [FrameBitsPerRow*NumRows-1:0]   FrameData,
  output logic [MaxFramesPerCol*NumCols-1:0]   FrameStrobe,
  output logic                                 busy,
  output logic [15:0]                          frames_done,
  output logic                                 err_sync,
  output logic                                 err_addr
`ifdef FRAME_CRC_EN
  ,
  output logic                                 err_crc
`endif
);

  localparam int unsigned DataW   = FrameBitsPerRow * NumRows;
  localparam int unsigned StrobeW = MaxFramesPerCol * NumCols;
  localparam int unsigned RowW    = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam int unsigned SCntW   = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;
  localparam logic [7:0]  SyncByte = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_CHECK,
    S_STROBE,
    S_GAP
  } state_t;

  state_t              state_q, state_d;
  logic [RowW-1:0]     row_q, row_d;
  logic [SCntW-1:0]    scnt_q, scnt_d;
  logic [7:0]          col_q, col_d;
  logic [7:0]          frame_q, frame_d;
  logic                addr_ok_q, addr_ok_d;
  logic [DataW-1:0]    frame_data_q, frame_data_d;
  logic [StrobeW-1:0]  strobe_q, strobe_d;
  logic [15:0]         done_q, done_d;
  logic                err_sync_q, err_sync_d;
  logic                err_addr_q, err_addr_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic                xfer;
  logic                enter_strobe;
  logic [15:0]         strobe_idx;
`ifdef FRAME_CRC_EN
  logic [31:0]         crc_q, crc_d;
  logic                err_crc_q, err_crc_d;
`endif

  assign xfer       = cfg.in_valid && in_ready_q;
  assign strobe_idx = 16'(col_q) * 16'(MaxFramesPerCol) + 16'(frame_q);

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    scnt_d       = scnt_q;
    col_d        = col_q;
    frame_d      = frame_q;
    addr_ok_d    = addr_ok_q;
    frame_data_d = frame_data_q;
    strobe_d     = strobe_q;
    done_d       = done_q;
    err_sync_d   = err_sync_q;
    err_addr_d   = err_addr_q;
    enter_strobe = 1'b0;
`ifdef FRAME_CRC_EN
    crc_d        = crc_q;
    err_crc_d    = err_crc_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          if (cfg.in_data[31:24] != SyncByte) begin
            err_sync_d = 1'b1;
          end else begin
            col_d     = cfg.in_data[23:16];
            frame_d   = cfg.in_data[15:8];
            addr_ok_d = (cfg.in_data[23:16] < 8'(NumCols)) &&
                        (cfg.in_data[15:8] < 8'(MaxFramesPerCol));
            if (!addr_ok_d) err_addr_d = 1'b1;
            row_d   = '0;
            state_d = S_DATA;
`ifdef FRAME_CRC_EN
            crc_d   = '0;
`endif
          end
        end
      end

      S_DATA: begin
        if (xfer) begin
          for (int unsigned r = 0; r < NumRows; r++) begin
            if (row_q == RowW'(r)) frame_data_d[r*FrameBitsPerRow +: FrameBitsPerRow] = cfg.in_data;
          end
`ifdef FRAME_CRC_EN
          crc_d = crc_q ^ cfg.in_data;
`endif
          if (row_q == RowW'(NumRows - 1)) begin
`ifdef FRAME_CRC_EN
            state_d = S_CHECK;
`else
            if (addr_ok_q) enter_strobe = 1'b1;
            else           state_d      = S_GAP;
`endif
          end else begin
            row_d = row_q + RowW'(1);
          end
        end
      end

`ifdef FRAME_CRC_EN
      S_CHECK: begin
        if (xfer) begin
          if (cfg.in_data == crc_q && addr_ok_q) begin
            enter_strobe = 1'b1;
          end else begin
            state_d = S_GAP;
            if (cfg.in_data != crc_q) err_crc_d = 1'b1;
          end
        end
      end
`endif

      S_STROBE: begin
        if (scnt_q == SCntW'(StrobeCycles - 1)) begin
          strobe_d = '0;
          state_d  = S_GAP;
        end else begin
          scnt_d = scnt_q + SCntW'(1);
        end
      end

      S_GAP: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    // Strobe rises on the same edge that loads the last data word.
    if (enter_strobe) begin
      state_d  = S_STROBE;
      strobe_d = StrobeW'(1) << strobe_idx;
      done_d   = done_q + 16'd1;
      scnt_d   = '0;
    end

    in_ready_d = (state_d == S_IDLE) || (state_d == S_DATA) || (state_d == S_CHECK);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge UserCLK) begin
    if (reset) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      scnt_q       <= '0;
      col_q        <= '0;
      frame_q      <= '0;
      addr_ok_q    <= 1'b0;
      frame_data_q <= '0;
      strobe_q     <= '0;
      done_q       <= '0;
      err_sync_q   <= 1'b0;
      err_addr_q   <= 1'b0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
`ifdef FRAME_CRC_EN
      crc_q        <= '0;
      err_crc_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      scnt_q       <= scnt_d;
      col_q        <= col_d;
      frame_q      <= frame_d;
      addr_ok_q    <= addr_ok_d;
      frame_data_q <= frame_data_d;
      strobe_q     <= strobe_d;
      done_q       <= done_d;
      err_sync_q   <= err_sync_d;
      err_addr_q   <= err_addr_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
`ifdef FRAME_CRC_EN
      crc_q        <= crc_d;
      err_crc_q    <= err_crc_d;
`endif
    end
  end

  assign cfg.in_ready  = in_ready_q;
  assign FrameData     = frame_data_q;
  assign FrameStrobe   = strobe_q;
  assign busy          = busy_q;
  assign frames_done   = done_q;
  assign err_sync      = err_sync_q;
  assign err_addr      = err_addr_q;
`ifdef FRAME_CRC_EN
  assign err_crc       = err_crc_q;
`endif

endmodule

// File: tb/tb_frame_column_loader.sv
// Directed self-checking bench for frame_column_loader (default parameters).
module tb_frame_column_loader;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] frame_data;
  logic [79:0]  frame_strobe;
  logic         busy;
  logic [15:0]  frames_done;
  logic         err_sync;
  logic         err_addr;
`ifdef FRAME_CRC_EN
  logic         err_crc;
`endif
  int           checks = 0;
  int           errors = 0;

  frame_column_loader_if bus();

  frame_column_loader dut (
    .UserCLK     (clk),
    .reset       (reset),
    .cfg         (bus),
    .FrameData   (frame_data),
    .FrameStrobe (frame_strobe),
    .busy        (busy),
    .frames_done (frames_done),
    .err_sync    (err_sync),
    .err_addr    (err_addr)
`ifdef FRAME_CRC_EN
    ,
    .err_crc     (err_crc)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one word and return right after the edge that transfers it.
  task automatic send_word(input logic [31:0] w);
    int n = 0;
    @(negedge clk);
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL send_word_timeout: in_ready=%b, required 1", bus.in_ready);
    end
    @(posedge clk);
  endtask

  // Drop in_valid at the first negedge after the last transfer (cycle 1 of the response).
  task automatic end_packet();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
    checks++; if (frame_data !== 128'd0) begin errors++; $display("FAIL rst_frame_data: got %h want 0", frame_data); end
    checks++; if (frame_strobe !== 80'd0) begin errors++; $display("FAIL rst_strobe: got %h want 0", frame_strobe); end
    checks++; if (busy !== 1'b0 || frames_done !== 16'd0) begin errors++; $display("FAIL rst_busy_done: got busy=%b done=%0d want 0/0", busy, frames_done); end
    checks++; if (err_sync !== 1'b0 || err_addr !== 1'b0) begin errors++; $display("FAIL rst_err: got sync=%b addr=%b want 0/0", err_sync, err_addr); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_basic();
    logic [79:0] exp_s;
    exp_s = '0;
    exp_s[45] = 1'b1;
    send_word(32'hA5020500);
    send_word(32'h11111111);
    send_word(32'h22222222);
    send_word(32'h33333333);
    send_word(32'h44444444);
    end_packet();
    checks++; if (frame_data !== 128'h44444444_33333333_22222222_11111111) begin errors++; $display("FAIL basic_data: got %h want 44444444333333332222222211111111", frame_data); end
    checks++; if (frame_strobe !== exp_s) begin errors++; $display("FAIL basic_strobe_c1: got %h want %h", frame_strobe, exp_s); end
    checks++; if (frames_done !== 16'd1) begin errors++; $display("FAIL basic_frames_done: got %0d want 1", frames_done); end
    checks++; if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL basic_ready_c1: got ready=%b busy=%b want 0/1", bus.in_ready, busy); end
    @(negedge clk);
    checks++; if (frame_strobe !== exp_s || bus.in_ready !== 1'b0) begin errors++; $display("FAIL basic_strobe_c2: got %h ready=%b want %h/0", frame_strobe, bus.in_ready, exp_s); end
    @(negedge clk);
    checks++; if (frame_strobe !== 80'd0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL basic_gap: got %h ready=%b want 0/0", frame_strobe, bus.in_ready); end
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got ready=%b busy=%b want 1/0", bus.in_ready, busy); end
  endtask

  task automatic test_bad_sync();
    logic [79:0] exp_s;
    exp_s = '0;
    exp_s[23] = 1'b1;
    send_word(32'h5A000000);
    end_packet();
    checks++; if (err_sync !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL sync_err: got err_sync=%b busy=%b want 1/0", err_sync, busy); end
    checks++; if (bus.in_ready !== 1'b1 || frames_done !== 16'd1) begin errors++; $display("FAIL sync_idle: got ready=%b done=%0d want 1/1", bus.in_ready, frames_done); end
    send_word(32'hA5010300);
    send_word(32'hAAAA0001);
    send_word(32'hAAAA0002);
    send_word(32'hAAAA0003);
    send_word(32'hAAAA0004);
    end_packet();
    checks++; if (frame_strobe !== exp_s || frames_done !== 16'd2) begin errors++; $display("FAIL sync_followup: got strobe=%h done=%0d want %h/2", frame_strobe, frames_done, exp_s); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_bad_addr();
    send_word(32'hA5040000);
    send_word(32'h0000000A);
    send_word(32'h0000000B);
    send_word(32'h0000000C);
    send_word(32'h0000000D);
    end_packet();
    checks++; if (err_addr !== 1'b1) begin errors++; $display("FAIL addr_err: got %b want 1", err_addr); end
    checks++; if (frame_data !== 128'h0000000D_0000000C_0000000B_0000000A) begin errors++; $display("FAIL addr_data: got %h want 0000000D0000000C0000000B0000000A", frame_data); end
    checks++; if (frame_strobe !== 80'd0 || frames_done !== 16'd2) begin errors++; $display("FAIL addr_nostrobe: got %h done=%0d want 0/2", frame_strobe, frames_done); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL addr_gap_ready: got %b want 0", bus.in_ready); end
    @(negedge clk);
    checks++; if (frame_strobe !== 80'd0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL addr_idle: got strobe=%h ready=%b busy=%b want 0/1/0", frame_strobe, bus.in_ready, busy); end
  endtask

  task automatic test_back_to_back();
    logic [31:0]  words[$];
    logic [79:0]  exp_s[3];
    logic [127:0] exp_d[3];
    logic [79:0]  prev_s;
    logic [127:0] prev_d;
    logic [31:0]  w;
    int           hdr_col[3];
    int           hdr_frm[3];
    int           idx = 0;
    int           k = 0;
    int           run_len = 0;
    int           hi_len = 0;
    hdr_col = '{0, 3, 2};
    hdr_frm = '{0, 19, 7};
    for (int p = 0; p < 3; p++) begin
      words.push_back({8'hA5, 8'(hdr_col[p]), 8'(hdr_frm[p]), 8'h00});
      exp_s[p] = '0;
      exp_s[p][hdr_col[p]*20 + hdr_frm[p]] = 1'b1;
      for (int r = 0; r < 4; r++) begin
        w = $urandom;
        words.push_back(w);
        exp_d[p][r*32 +: 32] = w;
      end
    end
    prev_s = frame_strobe;
    prev_d = frame_data;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      checks++; if ($countones(frame_strobe) > 1) begin errors++; $display("FAIL b2b_onehot: got %h want at most one bit", frame_strobe); end
      if (frame_strobe != 80'd0) begin
        if (prev_s == 80'd0) begin
          if (k < 3) begin
            checks++; if (frame_strobe !== exp_s[k]) begin errors++; $display("FAIL b2b_strobe%0d: got %h want %h", k, frame_strobe, exp_s[k]); end
            checks++; if (frame_data !== exp_d[k]) begin errors++; $display("FAIL b2b_data%0d: got %h want %h", k, frame_data, exp_d[k]); end
            if (k > 0) begin
              checks++; if (run_len != 6) begin errors++; $display("FAIL b2b_spacing%0d: got %0d idle cycles want 6", k, run_len); end
            end
          end else begin
            checks++; errors++; $display("FAIL b2b_extra_strobe: got %h want none", frame_strobe);
          end
          k++;
          hi_len = 0;
        end else begin
          checks++; if (frame_data !== prev_d) begin errors++; $display("FAIL b2b_data_stable: got %h want %h", frame_data, prev_d); end
        end
        hi_len++;
        run_len = 0;
      end else begin
        if (prev_s != 80'd0) begin
          checks++; if (hi_len != 2) begin errors++; $display("FAIL b2b_strobe_len: got %0d want 2", hi_len); end
        end
        run_len++;
      end
      prev_s = frame_strobe;
      prev_d = frame_data;
      if (idx < words.size()) begin
        bus.in_valid = 1'b1;
        if (bus.in_ready === 1'b1) begin
          bus.in_data = words[idx];
          idx++;
        end else begin
          bus.in_data = $urandom;
        end
      end else begin
        bus.in_valid = 1'b0;
      end
      if (k == 3 && idx == words.size() && frame_strobe == 80'd0) break;
    end
    bus.in_valid = 1'b0;
    checks++; if (k != 3) begin errors++; $display("FAIL b2b_count: got %0d strobes want 3", k); end
    checks++; if (frames_done !== 16'd5) begin errors++; $display("FAIL b2b_frames_done: got %0d want 5", frames_done); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_packet();
    logic [79:0] exp_s;
    exp_s = '0;
    exp_s[79] = 1'b1;
    send_word(32'hA5010100);
    send_word(32'hDEADBEEF);
    send_word(32'hCAFEF00D);
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++; if (frame_data !== 128'd0) begin errors++; $display("FAIL mid_rst_data: got %h want 0", frame_data); end
    checks++; if (busy !== 1'b0 || frame_strobe !== 80'd0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_state: got busy=%b strobe=%h ready=%b want 0/0/0", busy, frame_strobe, bus.in_ready); end
    checks++; if (frames_done !== 16'd0 || err_sync !== 1'b0 || err_addr !== 1'b0) begin errors++; $display("FAIL mid_rst_flags: got done=%0d sync=%b addr=%b want 0/0/0", frames_done, err_sync, err_addr); end
    reset = 1'b0;
    send_word(32'hA5031300);
    send_word(32'h01020304);
    send_word(32'h05060708);
    send_word(32'h090A0B0C);
    send_word(32'h0D0E0F10);
    end_packet();
    checks++; if (frame_strobe !== exp_s) begin errors++; $display("FAIL mid_after_strobe: got %h want %h", frame_strobe, exp_s); end
    checks++; if (frame_data !== 128'h0D0E0F10_090A0B0C_05060708_01020304 || frames_done !== 16'd1) begin errors++; $display("FAIL mid_after_data: got %h done=%0d want 0D0E0F10090A0B0C0506070801020304/1", frame_data, frames_done); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_frame_bound();
    send_word(32'hA5001400);
    send_word(32'h00000001);
    send_word(32'h00000002);
    send_word(32'h00000003);
    send_word(32'h00000004);
    end_packet();
    checks++; if (err_addr !== 1'b1 || frame_strobe !== 80'd0) begin errors++; $display("FAIL frame_bound: got err_addr=%b strobe=%h want 1/0", err_addr, frame_strobe); end
    @(negedge clk);
    checks++; if (frame_strobe !== 80'd0 || frames_done !== 16'd1) begin errors++; $display("FAIL frame_bound_done: got strobe=%h done=%0d want 0/1", frame_strobe, frames_done); end
  endtask

`ifdef FRAME_CRC_EN
  task automatic test_crc();
    logic [79:0] exp_s;
    exp_s = '0;
    exp_s[1] = 1'b1;
    send_word(32'hA5000100);
    send_word(32'h00000001);
    send_word(32'h00000002);
    send_word(32'h00000004);
    send_word(32'h00000008);
    send_word(32'h0000000F);
    end_packet();
    checks++; if (frame_strobe !== exp_s || frames_done !== 16'd2) begin errors++; $display("FAIL crc_good: got strobe=%h done=%0d want %h/2", frame_strobe, frames_done, exp_s); end
    checks++; if (err_crc !== 1'b0) begin errors++; $display("FAIL crc_good_flag: got %b want 0", err_crc); end
    repeat (3) @(negedge clk);
    send_word(32'hA5000100);
    send_word(32'h00000001);
    send_word(32'h00000002);
    send_word(32'h00000004);
    send_word(32'h00000008);
    send_word(32'h0000000E);
    end_packet();
    checks++; if (frame_strobe !== 80'd0 || err_crc !== 1'b1) begin errors++; $display("FAIL crc_bad: got strobe=%h err_crc=%b want 0/1", frame_strobe, err_crc); end
    @(negedge clk);
    checks++; if (frame_strobe !== 80'd0 || frames_done !== 16'd2) begin errors++; $display("FAIL crc_bad_done: got strobe=%h done=%0d want 0/2", frame_strobe, frames_done); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_bad_sync();
    test_bad_addr();
    test_back_to_back();
    test_reset_mid_packet();
    test_frame_bound();
`ifdef FRAME_CRC_EN
    test_crc();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
